exposure_timer: RTL and testbench

- Parametrised exposure-duration timer for the digital-camera controller; successor to the fixed 5-bit exposure counter.
- Counts a programmed exposure length, in units of PRESCALE clock cycles, after a start request.
- Signals completion with a one-cycle done pulse and a sticky overflow flag.
- Adds abort, busy/remaining status and an optional retrigger mode. The flag sequencer consumes ovf/done to end the exposure phase.

---
 rtl/camera_timer_pkg.sv | 19 +
 rtl/tick_prescaler.sv | 35 +++
 rtl/exposure_timer.sv | 95 +++++++++
 tb/tb_exposure_timer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/camera_timer_pkg.sv
// Shared constants and types for the camera exposure timer slice.
package camera_timer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_t;

    localparam int unsigned EXP_TIME_W_DEF   = 5;
    localparam int unsigned EXP_PRESCALE_DEF = 1;

    // Prescale counter width: $clog2(PRESCALE+1), never less than one bit.
    function automatic int unsigned prescale_width(input int unsigned prescale);
        int unsigned w;
        w = $clog2(prescale + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the clock into exposure units: tick is high while running with the counter at zero.
module tick_prescaler
    import camera_timer_pkg::*;
#(
    parameter int unsigned PRESCALE = EXP_PRESCALE_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic run,
    output logic tick
);

    localparam int unsigned    CW     = prescale_width(PRESCALE);
    localparam logic [CW-1:0]  RELOAD = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= RELOAD;
        end else if (run) begin
            if (cnt == '0) begin
                cnt <= RELOAD;
            end else begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    assign tick = run && (cnt == '0);

endmodule

// File: rtl/exposure_timer.sv
// Exposure-duration timer: counts ex_time units of PRESCALE cycles, then pulses done and sets ovf.
// Optional retrigger of a running exposure: define EXPOSURE_TIMER_RETRIGGER_EN.
module exposure_timer
    import camera_timer_pkg::*;
#(
    parameter int unsigned TIME_W   = EXP_TIME_W_DEF,
    parameter int unsigned PRESCALE = EXP_PRESCALE_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [TIME_W-1:0] ex_time,
    output logic              busy,
    output logic [TIME_W-1:0] remaining,
    output logic              done,
    output logic              ovf
);

    state_t            state, state_n;
    logic [TIME_W-1:0] remaining_n;
    logic              done_n;
    logic              ovf_n;
    logic              load;
    logic              run;
    logic              tick;

    // Kept independent of abort/start so tick never feeds back into its own enable.
    assign run  = (state == ST_COUNT) && (remaining != '0);
    assign busy = (state == ST_COUNT);

    tick_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .load (load),
        .run  (run),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            remaining <= '0;
            done      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            state     <= state_n;
            remaining <= remaining_n;
            done      <= done_n;
            ovf       <= ovf_n;
        end
    end

    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        done_n      = 1'b0;
        ovf_n       = ovf;
        load        = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_n     = ST_COUNT;
                    remaining_n = ex_time;
                    ovf_n       = 1'b0;
                    load        = 1'b1;
                end
            end
            ST_COUNT: begin
                if (abort) begin
                    state_n     = ST_IDLE;
                    remaining_n = '0;
`ifdef EXPOSURE_TIMER_RETRIGGER_EN
                end else if (start) begin
                    remaining_n = ex_time;
                    ovf_n       = 1'b0;
                    load        = 1'b1;
`endif
                end else if (remaining == '0) begin
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                    ovf_n   = 1'b1;
                end else if (tick) begin
                    remaining_n = remaining - TIME_W'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_exposure_timer.sv
// Self-checking bench for exposure_timer: PRESCALE=1 and PRESCALE=4 instances on shared stimulus.
module tb_exposure_timer;

    localparam int W = 5;

    logic         clk     = 1'b0;
    logic         reset   = 1'b1;
    logic         start   = 1'b0;
    logic         abort   = 1'b0;
    logic [W-1:0] ex_time = '0;

    logic         busy1, done1, ovf1;
    logic [W-1:0] rem1;
    logic         busy4, done4, ovf4;
    logic [W-1:0] rem4;

    int errors = 0;
    int checks = 0;

    exposure_timer #(.TIME_W(W), .PRESCALE(1)) u_p1 (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .ex_time(ex_time),
        .busy(busy1), .remaining(rem1), .done(done1), .ovf(ovf1)
    );

    exposure_timer #(.TIME_W(W), .PRESCALE(4)) u_p4 (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .ex_time(ex_time),
        .busy(busy4), .remaining(rem4), .done(done4), .ovf(ovf4)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Timeline model: an exposure is k edges into its run; remaining = ex - k/P,
    // completion on the edge after k reaches ex*P.
    bit m_active[2];
    int m_k[2];
    int m_ex[2];
    bit m_ovf[2];
    bit m_done[2];
    bit model_valid = 1'b0;

    function automatic int ps(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            m_done[i] = 1'b0;
            if (reset) begin
                m_active[i] = 1'b0;
                m_ovf[i]    = 1'b0;
                m_k[i]      = 0;
            end else if (m_active[i]) begin
                if (abort) begin
                    m_active[i] = 1'b0;
`ifdef EXPOSURE_TIMER_RETRIGGER_EN
                end else if (start) begin
                    m_ex[i]  = int'(ex_time);
                    m_k[i]   = 0;
                    m_ovf[i] = 1'b0;
`endif
                end else if (m_k[i] == m_ex[i] * ps(i)) begin
                    m_active[i] = 1'b0;
                    m_done[i]   = 1'b1;
                    m_ovf[i]    = 1'b1;
                end else begin
                    m_k[i]++;
                end
            end else if (start && !abort) begin
                m_active[i] = 1'b1;
                m_k[i]      = 0;
                m_ex[i]     = int'(ex_time);
                m_ovf[i]    = 1'b0;
            end
        end
        model_valid = 1'b1;
    end

    function automatic int exp_rem(input int i);
        return m_active[i] ? (m_ex[i] - m_k[i] / ps(i)) : 0;
    endfunction

    always @(negedge clk) begin
        if (model_valid) begin
            check("busy_p1", busy1, m_active[0]);
            check("rem_p1",  rem1,  exp_rem(0));
            check("done_p1", done1, m_done[0]);
            check("ovf_p1",  ovf1,  m_ovf[0]);
            check("busy_p4", busy4, m_active[1]);
            check("rem_p4",  rem4,  exp_rem(1));
            check("done_p4", done4, m_done[1]);
            check("ovf_p4",  ovf4,  m_ovf[1]);
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic start_pulse(input int ex);
        ex_time = W'(ex);
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // Edges from the last accept edge until done is seen; -1 if the budget expires.
    task automatic wait_done(input int sel, input int budget, output int edges);
        edges = -1;
        for (int e = 1; e <= budget; e++) begin
            @(negedge clk);
            if ((sel == 0) ? done1 : done4) begin
                edges = e;
                break;
            end
        end
    endtask

    initial begin
        int e;
        @(negedge clk);
        do_reset();
        check("reset_busy", busy1, 0);
        check("reset_rem",  rem1,  0);
        check("reset_done", done1, 0);
        check("reset_ovf",  ovf1,  0);

        // ex=5, P=1: remaining 5..0, done 6 edges after accept
        start_pulse(5);
        check("t1_rem_first", rem1, 5);
        check("t1_busy", busy1, 1);
        wait_done(0, 40, e);
        check("t1_latency", e, 6);
        check("t1_busy_at_done", busy1, 0);
        @(negedge clk);
        check("t1_ovf_after", ovf1, 1);
        check("t1_done_single", done1, 0);

        // ex=3, P=4: done 13 edges after; ovf held until next accept
        do_reset();
        start_pulse(3);
        check("t2_rem_first", rem4, 3);
        wait_done(1, 60, e);
        check("t2_latency", e, 13);
        repeat (3) @(negedge clk);
        check("t2_ovf_held", ovf4, 1);
        start_pulse(2);
        check("t2_ovf_cleared", ovf4, 0);
        check("t2_rem_restart", rem4, 2);
        wait_done(1, 60, e);
        check("t2_latency2", e, 9);

        // ex=0 then a start in the done cycle is accepted
        do_reset();
        start_pulse(0);
        check("t3_busy_zero", busy1, 1);
        wait_done(0, 10, e);
        check("t3_latency_zero", e, 1);
        start_pulse(2);
        check("t3_accept_in_done", busy1, 1);
        check("t3_rem", rem1, 2);
        wait_done(0, 10, e);
        check("t3_latency2", e, 3);

        // ex=31, P=1: no wrap
        do_reset();
        start_pulse(31);
        wait_done(0, 100, e);
        check("t4_latency_max", e, 32);

        // abort at remaining=2
        do_reset();
        start_pulse(5);
        repeat (3) @(negedge clk);
        check("t5_rem_before_abort", rem1, 2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t5_busy", busy1, 0);
        check("t5_rem",  rem1,  0);
        check("t5_ovf",  ovf1,  0);
        wait_done(0, 8, e);
        check("t5_no_done", e, -1);
        ex_time = W'(4);
        start   = 1'b1;
        abort   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        abort   = 1'b0;
        check("t5_start_abort_p1", busy1, 0);
        check("t5_start_abort_p4", busy4, 0);

        // reset mid-exposure, then a fresh ex=4
        do_reset();
        start_pulse(9);
        repeat (3) @(negedge clk);
        do_reset();
        check("t6_busy", busy1, 0);
        check("t6_rem",  rem1,  0);
        check("t6_done", done1, 0);
        check("t6_ovf",  ovf1,  0);
        start_pulse(4);
        wait_done(0, 20, e);
        check("t6_latency", e, 5);

        // start ex=9 while remaining=3
        do_reset();
        start_pulse(6);
        repeat (3) @(negedge clk);
        check("t7_rem_before", rem1, 3);
        ex_time = W'(9);
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
`ifdef EXPOSURE_TIMER_RETRIGGER_EN
        check("t7_rem_reload", rem1, 9);
        wait_done(0, 30, e);
        check("t7_latency", e, 10);
`else
        check("t7_rem_ignored", rem1, 2);
        wait_done(0, 30, e);
        check("t7_latency", e, 3);
`endif

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
